// File: rtl/spi_slave_if.sv
// SPI mode-0 responder: oversampled pins, byte-wide rx handshake and a
// double-buffered tx path so a host can sustain continuous bursts.
module spi_slave_if #(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] UNDERRUN_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       tx_underrun,
  input  logic       clr_flags,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_d;
  logic                   cs_d;

  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;

  logic [0:0]             state;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_sh;
  logic [7:0]             tx_sh;
  logic [7:0]             tx_buf;
  logic                   tx_full;

  logic                   in_active;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   spi_rise_en;
  logic                   spi_fall_en;
  logic                   fetch;
  logic                   tx_load;
  logic                   rx_done;

  // synchronizer stage: pins -> clk domain, plus one extra flop for edges
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];

  assign in_active   = (state == ST_ACTIVE);
  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;
  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;

  // clock edges coinciding with deselect are dropped along with the partial byte
  assign spi_rise_en = in_active && !cs_rise && sclk_rise;
  assign spi_fall_en = in_active && !cs_rise && sclk_fall;

  assign fetch       = (!in_active && cs_fall) || (spi_fall_en && (bit_cnt == 3'd0));
  assign tx_load     = tx_valid && !tx_full;
  assign rx_done     = spi_rise_en && (bit_cnt == 3'd7);

  // protocol stage: state, shifters and host handshakes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      rx_sh       <= 8'h00;
      tx_sh       <= 8'h00;
      tx_buf      <= 8'h00;
      tx_full     <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      // a fetch sees the old buffer; a same-cycle load lands for the next fetch
      tx_full <= (tx_full && !fetch) || tx_load;
      if (tx_load)
        tx_buf <= tx_data;

      if (fetch)
        tx_sh <= tx_full ? tx_buf : UNDERRUN_BYTE;
      else if (spi_fall_en)
        tx_sh <= {tx_sh[6:0], 1'b0};

      if (!in_active && cs_fall) begin
        state   <= ST_ACTIVE;
        bit_cnt <= 3'd0;
      end else if (in_active && cs_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= 3'd0;
      end else if (spi_rise_en) begin
        rx_sh   <= {rx_sh[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (rx_done) begin
        rx_data  <= {rx_sh[6:0], mosi_s};
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (rx_done && rx_valid && !rx_ready)
        rx_overrun <= 1'b1;
      else if (clr_flags)
        rx_overrun <= 1'b0;

      if (fetch && !tx_full)
        tx_underrun <= 1'b1;
      else if (clr_flags)
        tx_underrun <= 1'b0;
    end
  end

  assign spi_miso = in_active ? tx_sh[7] : 1'b1;
  assign tx_ready = ~tx_full;
  assign busy     = ~cs_d;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a mode-0 master at clk/8 against a host
// model, checking bytes, flags, aborts and asynchronous reset.
module tb_spi_slave_if;

  logic       clk;
  logic       resetn;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_cs;
  logic       spi_miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       clr_flags;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] mi;

  spi_slave_if #(.SYNC_STAGES(2), .UNDERRUN_BYTE(8'h00)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_cs     (spi_cs),
    .spi_miso   (spi_miso),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .tx_underrun(tx_underrun),
    .clr_flags  (clr_flags),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic rx_pop();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    tick(1);
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs = 1'b1;
    tick(8);
  endtask

  // hold_last leaves spi_clk high after the final rising edge
  task automatic spi_bits(input logic [7:0] mo, input int n, input bit hold_last,
                          output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = mo[7-i];
      tick(4);
      miso_b   = {miso_b[6:0], spi_miso};
      spi_clk  = 1'b1;
      tick(4);
      if (!(hold_last && (i == n - 1)))
        spi_clk = 1'b0;
    end
  endtask

  task automatic spi_fall();
    spi_clk = 1'b0;
    tick(4);
  endtask

  task automatic wait_tx_ready();
    for (int k = 0; k < 20 && !tx_ready; k++)
      tick(1);
    chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    resetn    = 1'b0;
    spi_clk   = 1'b0;
    spi_mosi  = 1'b0;
    spi_cs    = 1'b1;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    rx_ready  = 1'b0;
    clr_flags = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(2);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_miso", {31'd0, spi_miso}, 32'd1);
    chk("rst_flags", {30'd0, rx_overrun, tx_underrun}, 32'd0);

    // single byte
    tx_push(8'hA5);
    cs_low();
    spi_bits(8'h3C, 8, 1'b1, mi);
    chk("t1_miso", {24'd0, mi}, 32'hA5);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("t1_rx_data", {24'd0, rx_data}, 32'h3C);
    chk("t1_flags", {30'd0, rx_overrun, tx_underrun}, 32'd0);
    rx_pop();
    chk("t1_rx_cleared", {31'd0, rx_valid}, 32'd0);
    spi_fall();
    cs_high();
    chk("t1_busy_off", {31'd0, busy}, 32'd0);
    chk("t1_trail_underrun", {31'd0, tx_underrun}, 32'd1);
    clr_pulse();
    chk("t1_clr", {31'd0, tx_underrun}, 32'd0);

    // back-to-back burst
    tx_push(8'h11);
    cs_low();
    wait_tx_ready();
    tx_push(8'h22);
    chk("t2_tx_full", {31'd0, tx_ready}, 32'd0);
    spi_bits(8'hC0, 8, 1'b1, mi);
    chk("t2_miso0", {24'd0, mi}, 32'h11);
    chk("t2_rx0", {24'd0, rx_data}, 32'hC0);
    rx_pop();
    spi_fall();
    spi_bits(8'hC1, 8, 1'b1, mi);
    chk("t2_miso1", {24'd0, mi}, 32'h22);
    chk("t2_rx1", {24'd0, rx_data}, 32'hC1);
    chk("t2_rx1_valid", {31'd0, rx_valid}, 32'd1);
    chk("t2_flags", {30'd0, rx_overrun, tx_underrun}, 32'd0);
    rx_pop();
    spi_fall();
    cs_high();
    clr_pulse();

    // underrun
    cs_low();
    spi_bits(8'h7E, 8, 1'b0, mi);
    cs_high();
    chk("t3_miso", {24'd0, mi}, 32'h00);
    chk("t3_underrun", {31'd0, tx_underrun}, 32'd1);
    chk("t3_rx", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h7E});
    rx_pop();
    clr_pulse();
    chk("t3_underrun_clr", {31'd0, tx_underrun}, 32'd0);

    // overrun
    cs_low();
    spi_bits(8'h01, 8, 1'b0, mi);
    spi_bits(8'h02, 8, 1'b0, mi);
    cs_high();
    chk("t4_rx_data", {24'd0, rx_data}, 32'h02);
    chk("t4_overrun", {31'd0, rx_overrun}, 32'd1);
    chk("t4_rx_valid", {31'd0, rx_valid}, 32'd1);
    rx_pop();
    clr_pulse();
    chk("t4_overrun_clr", {31'd0, rx_overrun}, 32'd0);

    // cs abort mid-byte
    tx_push(8'hC3);
    cs_low();
    spi_bits(8'hFF, 5, 1'b0, mi);
    cs_high();
    chk("t5_no_partial", {31'd0, rx_valid}, 32'd0);
    tx_push(8'h69);
    cs_low();
    spi_bits(8'h5A, 8, 1'b0, mi);
    cs_high();
    chk("t5_miso", {24'd0, mi}, 32'h69);
    chk("t5_rx", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h5A});
    rx_pop();
    chk("t5_one_valid", {31'd0, rx_valid}, 32'd0);
    clr_pulse();

    // asynchronous reset mid-byte
    cs_low();
    tx_push(8'hAA);
    spi_bits(8'hF0, 3, 1'b0, mi);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("t6_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("t6_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("t6_rx_data", {24'd0, rx_data}, 32'h00);
    chk("t6_flags", {30'd0, rx_overrun, tx_underrun}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_miso", {31'd0, spi_miso}, 32'd1);
    spi_cs  = 1'b1;
    spi_clk = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(5);
    tx_push(8'h96);
    cs_low();
    spi_bits(8'h96, 8, 1'b1, mi);
    chk("t6_post_miso", {24'd0, mi}, 32'h96);
    chk("t6_post_rx", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h96});
    chk("t6_post_underrun", {31'd0, tx_underrun}, 32'd0);
    rx_pop();
    spi_fall();
    cs_high();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
